kv_ledger: RTL and testbench

//  Key-value balance ledger; sits directly downstream of the packet transfer stage.

---
 rtl/kv_ledger_pkg.sv | 24 ++
 rtl/kv_req_fifo.sv | 51 +++++
 rtl/kv_ledger.sv | 192 +++++++++++++++++++
 tb/tb_kv_ledger.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kv_ledger_pkg.sv
// Shared codes for the key/balance ledger: request signals, kinds,
// response status values and the controller state encoding.
package kv_ledger_pkg;

   localparam logic [1:0] SIG_IDLE  = 2'd0;
   localparam logic [1:0] SIG_QUERY = 2'd1;
   localparam logic [1:0] SIG_TXN   = 2'd2;

   localparam logic KIND_DEBIT  = 1'b0;
   localparam logic KIND_CREDIT = 1'b1;

   localparam logic [1:0] ST_OK        = 2'd0;
   localparam logic [1:0] ST_NOT_FOUND = 2'd1;
   localparam logic [1:0] ST_RANGE     = 2'd2;
   localparam logic [1:0] ST_FULL      = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_UPDATE,
      S_RESP
   } state_t;

endpackage

// File: rtl/kv_req_fifo.sv
// Small synchronous request queue with full/empty flags.
// Pushes while full are ignored; the caller flags them as drops.
module kv_req_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_wr;
   logic          w_rd;

   assign full  = (r_cnt == CW'(DEPTH));
   assign empty = (r_cnt == '0);
   assign w_wr  = push && !full;
   assign w_rd  = pop && !empty;
   assign rdata = r_mem[r_rp];

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) r_wp <= (r_wp == LAST) ? '0 : r_wp + 1'b1;
         if (w_rd) r_rp <= (r_rp == LAST) ? '0 : r_rp + 1'b1;
         if (w_wr && !w_rd) r_cnt <= r_cnt + 1'b1;
         else if (!w_wr && w_rd) r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/kv_ledger.sv
// Key/balance ledger: queued debit/credit/query requests resolved by a
// fixed-latency linear scan of the table, one response per request.
module kv_ledger
   import kv_ledger_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int KEY_W      = 32,
   parameter int VAL_W      = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic             tick_in,
   input  logic             reset_in,
   input  logic [1:0]       signal,
   input  logic [KEY_W-1:0] key,
   input  logic             transact_kind,
   input  logic [VAL_W-1:0] transact_value,
   output logic             busy,
   output logic             resp_valid,
   output logic [1:0]       resp_status,
   output logic [KEY_W-1:0] resp_key,
   output logic [VAL_W-1:0] resp_balance,
   output logic             drop_sticky
);

   localparam int IW = $clog2(DEPTH);
   localparam int RW = 2 + KEY_W + 1 + VAL_W;
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [RW-1:0] w_rdata;

   state_t           r_state;
   logic [1:0]       r_sig;
   logic [KEY_W-1:0] r_key;
   logic             r_kind;
   logic [VAL_W-1:0] r_val;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    r_hit_idx;
   logic [IW-1:0]    r_free_idx;
   logic             r_hit;
   logic             r_free;

   logic [KEY_W-1:0] r_keys [DEPTH];
   logic [VAL_W-1:0] r_bals [DEPTH];
   logic [DEPTH-1:0] r_valid;

   logic [VAL_W-1:0] w_cur;
   logic [VAL_W:0]   w_sum;
   logic [VAL_W:0]   w_diff;
   logic [1:0]       w_st;
   logic [VAL_W-1:0] w_res;
   logic             w_we;
   logic             w_alloc;
   logic [IW-1:0]    w_widx;
   logic [VAL_W-1:0] w_wbal;

   assign w_push = !((signal == SIG_IDLE) || (signal == 2'b11));
   assign w_pop  = (r_state == S_IDLE) && !w_empty;
   assign busy   = (r_state != S_IDLE) || !w_empty;

   kv_req_fifo #(
      .W     (RW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (tick_in),
      .rst   (reset_in),
      .push  (w_push),
      .pop   (w_pop),
      .wdata ({signal, key, transact_kind, transact_value}),
      .rdata (w_rdata),
      .full  (w_full),
      .empty (w_empty)
   );

   // Wide sum/difference so carry and borrow are visible before any write.
   assign w_cur  = r_bals[r_hit_idx];
   assign w_sum  = {1'b0, w_cur} + {1'b0, r_val};
   assign w_diff = {1'b0, w_cur} - {1'b0, r_val};

   always_comb begin
      w_st    = ST_OK;
      w_res   = '0;
      w_we    = 1'b0;
      w_alloc = 1'b0;
      w_widx  = r_hit_idx;
      w_wbal  = w_cur;
      if (r_sig == SIG_QUERY) begin
         if (r_hit) w_res = w_cur;
         else       w_st  = ST_NOT_FOUND;
      end else if (r_kind == KIND_CREDIT) begin
         if (r_hit) begin
            w_res = w_cur;
            if (w_sum[VAL_W]) begin
               w_st = ST_RANGE;
            end else begin
               w_res  = w_sum[VAL_W-1:0];
               w_wbal = w_sum[VAL_W-1:0];
               w_we   = 1'b1;
            end
         end else if (r_free) begin
            w_res   = r_val;
            w_wbal  = r_val;
            w_widx  = r_free_idx;
            w_we    = 1'b1;
            w_alloc = 1'b1;
         end else begin
            w_st = ST_FULL;
         end
      end else begin
         if (!r_hit) begin
            w_st = ST_NOT_FOUND;
         end else if (w_diff[VAL_W]) begin
            w_st  = ST_RANGE;
            w_res = w_cur;
         end else begin
            w_res  = w_diff[VAL_W-1:0];
            w_wbal = w_diff[VAL_W-1:0];
            w_we   = 1'b1;
         end
      end
   end

   always_ff @(posedge tick_in) begin
      if (r_state == S_UPDATE && w_we) begin
         r_bals[w_widx] <= w_wbal;
         if (w_alloc) r_keys[w_widx] <= r_key;
      end
   end

   always_ff @(posedge tick_in or posedge reset_in) begin
      if (reset_in) begin
         r_state      <= S_IDLE;
         r_sig        <= '0;
         r_key        <= '0;
         r_kind       <= 1'b0;
         r_val        <= '0;
         r_idx        <= '0;
         r_hit_idx    <= '0;
         r_free_idx   <= '0;
         r_hit        <= 1'b0;
         r_free       <= 1'b0;
         r_valid      <= '0;
         resp_valid   <= 1'b0;
         resp_status  <= '0;
         resp_key     <= '0;
         resp_balance <= '0;
         drop_sticky  <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         if (w_push && w_full) drop_sticky <= 1'b1;
         unique case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  {r_sig, r_key, r_kind, r_val} <= w_rdata;
                  r_idx   <= '0;
                  r_hit   <= 1'b0;
                  r_free  <= 1'b0;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (r_valid[r_idx] && r_keys[r_idx] == r_key) begin
                  r_hit     <= 1'b1;
                  r_hit_idx <= r_idx;
               end
               if (!r_valid[r_idx] && !r_free) begin
                  r_free     <= 1'b1;
                  r_free_idx <= r_idx;
               end
               if (r_idx == LAST) r_state <= S_UPDATE;
               else               r_idx   <= r_idx + 1'b1;
            end
            S_UPDATE: begin
               if (w_alloc) r_valid[w_widx] <= 1'b1;
               resp_status  <= w_st;
               resp_balance <= w_res;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               resp_valid <= 1'b1;
               resp_key   <= r_key;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kv_ledger.sv
// Directed bench for kv_ledger at DEPTH=4, FIFO_DEPTH=2.
// Each scenario task drives requests and checks responses inline.
module tb_kv_ledger;
   import kv_ledger_pkg::*;

   logic        tick_in = 1'b0;
   logic        reset_in = 1'b1;
   logic [1:0]  signal = 2'd0;
   logic [31:0] key = '0;
   logic        transact_kind = 1'b0;
   logic [31:0] transact_value = '0;
   logic        busy;
   logic        resp_valid;
   logic [1:0]  resp_status;
   logic [31:0] resp_key;
   logic [31:0] resp_balance;
   logic        drop_sticky;

   int tests = 0;
   int fails = 0;

   always #5 tick_in = ~tick_in;

   kv_ledger #(
      .DEPTH      (4),
      .KEY_W      (32),
      .VAL_W      (32),
      .FIFO_DEPTH (2)
   ) dut (
      .tick_in        (tick_in),
      .reset_in       (reset_in),
      .signal         (signal),
      .key            (key),
      .transact_kind  (transact_kind),
      .transact_value (transact_value),
      .busy           (busy),
      .resp_valid     (resp_valid),
      .resp_status    (resp_status),
      .resp_key       (resp_key),
      .resp_balance   (resp_balance),
      .drop_sticky    (drop_sticky)
   );

   task automatic send(input logic [1:0] s, input logic [31:0] k,
                       input logic kd, input logic [31:0] v);
      @(negedge tick_in);
      signal = s;
      key = k;
      transact_kind = kd;
      transact_value = v;
      @(posedge tick_in);
      #1;
      signal = SIG_IDLE;
      key = '0;
      transact_kind = 1'b0;
      transact_value = '0;
   endtask

   task automatic wait_resp(output logic got, output logic [1:0] st,
                            output logic [31:0] k, output logic [31:0] b,
                            output int n);
      got = 1'b0;
      st = '0;
      k = '0;
      b = '0;
      n = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(posedge tick_in);
         #1;
         n++;
         if (resp_valid) begin
            got = 1'b1;
            st = resp_status;
            k = resp_key;
            b = resp_balance;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge tick_in);
      reset_in = 1'b1;
      @(negedge tick_in);
      reset_in = 1'b0;
   endtask

   task automatic test_reset();
      logic [68:0] obs;
      obs = {busy, resp_valid, resp_status, resp_key, resp_balance, drop_sticky};
      tests++;
      if (obs !== '0) begin
         fails++;
         $display("FAIL reset_outputs got=%h exp=0", obs);
      end
   endtask

   task automatic test_credit_new();
      logic got;
      logic [1:0] st;
      logic [31:0] k, b;
      int n;
      send(SIG_TXN, 32'h0A, KIND_CREDIT, 32'd100);
      wait_resp(got, st, k, b, n);
      tests++;
      if (n !== 7) begin
         fails++;
         $display("FAIL credit_latency got=%0d exp=7", n);
      end
      tests++;
      if ({got, st, k, b} !== {1'b1, ST_OK, 32'h0A, 32'd100}) begin
         fails++;
         $display("FAIL credit_new got=%h exp=%h", {got, st, k, b},
                  {1'b1, ST_OK, 32'h0A, 32'd100});
      end
      @(posedge tick_in);
      #1;
      tests++;
      if (resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL strobe_width got=%b exp=0", resp_valid);
      end
   endtask

   task automatic test_debit_query();
      logic got;
      logic [1:0] st;
      logic [31:0] k, b;
      int n;
      send(SIG_TXN, 32'h0A, KIND_DEBIT, 32'd30);
      wait_resp(got, st, k, b, n);
      tests++;
      if ({got, st, k, b} !== {1'b1, ST_OK, 32'h0A, 32'd70}) begin
         fails++;
         $display("FAIL debit_ok got=%h exp=%h", {got, st, k, b},
                  {1'b1, ST_OK, 32'h0A, 32'd70});
      end
      send(SIG_TXN, 32'h0A, KIND_DEBIT, 32'd200);
      wait_resp(got, st, k, b, n);
      tests++;
      if ({got, st, k, b} !== {1'b1, ST_RANGE, 32'h0A, 32'd70}) begin
         fails++;
         $display("FAIL debit_range got=%h exp=%h", {got, st, k, b},
                  {1'b1, ST_RANGE, 32'h0A, 32'd70});
      end
      send(SIG_QUERY, 32'h0A, KIND_DEBIT, 32'd0);
      wait_resp(got, st, k, b, n);
      tests++;
      if ({got, st, k, b} !== {1'b1, ST_OK, 32'h0A, 32'd70}) begin
         fails++;
         $display("FAIL query_hit got=%h exp=%h", {got, st, k, b},
                  {1'b1, ST_OK, 32'h0A, 32'd70});
      end
   endtask

   task automatic test_back_to_back();
      logic got;
      logic [1:0] st;
      logic [31:0] k, b;
      int n;
      send(SIG_TXN, 32'h0A, KIND_DEBIT, 32'd20);
      send(SIG_TXN, 32'h0B, KIND_CREDIT, 32'd20);
      wait_resp(got, st, k, b, n);
      tests++;
      if ({got, st, k, b} !== {1'b1, ST_OK, 32'h0A, 32'd50}) begin
         fails++;
         $display("FAIL b2b_first got=%h exp=%h", {got, st, k, b},
                  {1'b1, ST_OK, 32'h0A, 32'd50});
      end
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL b2b_busy got=%b exp=1", busy);
      end
      wait_resp(got, st, k, b, n);
      tests++;
      if ({got, st, k, b} !== {1'b1, ST_OK, 32'h0B, 32'd20}) begin
         fails++;
         $display("FAIL b2b_second got=%h exp=%h", {got, st, k, b},
                  {1'b1, ST_OK, 32'h0B, 32'd20});
      end
   endtask

   task automatic test_full_range();
      logic got;
      logic [1:0] st;
      logic [31:0] k, b;
      int n;
      logic [31:0] vals [4];
      vals[0] = 32'h20;
      vals[1] = 32'd5;
      vals[2] = 32'd1;
      vals[3] = 32'd2;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(SIG_TXN, 32'h10 + i, KIND_CREDIT, vals[i]);
         wait_resp(got, st, k, b, n);
         tests++;
         if ({got, st, k, b} !== {1'b1, ST_OK, 32'h10 + i, vals[i]}) begin
            fails++;
            $display("FAIL fill_%0d got=%h exp=%h", i, {got, st, k, b},
                     {1'b1, ST_OK, 32'h10 + i, vals[i]});
         end
      end
      send(SIG_TXN, 32'h14, KIND_CREDIT, 32'd7);
      wait_resp(got, st, k, b, n);
      tests++;
      if ({got, st, k, b} !== {1'b1, ST_FULL, 32'h14, 32'd0}) begin
         fails++;
         $display("FAIL table_full got=%h exp=%h", {got, st, k, b},
                  {1'b1, ST_FULL, 32'h14, 32'd0});
      end
      send(SIG_TXN, 32'h77, KIND_DEBIT, 32'd5);
      wait_resp(got, st, k, b, n);
      tests++;
      if ({got, st, k, b} !== {1'b1, ST_NOT_FOUND, 32'h77, 32'd0}) begin
         fails++;
         $display("FAIL debit_miss got=%h exp=%h", {got, st, k, b},
                  {1'b1, ST_NOT_FOUND, 32'h77, 32'd0});
      end
      send(SIG_TXN, 32'h10, KIND_CREDIT, 32'hFFFF_FFF0);
      wait_resp(got, st, k, b, n);
      tests++;
      if ({got, st, k, b} !== {1'b1, ST_RANGE, 32'h10, 32'h20}) begin
         fails++;
         $display("FAIL credit_carry got=%h exp=%h", {got, st, k, b},
                  {1'b1, ST_RANGE, 32'h10, 32'h20});
      end
      send(SIG_TXN, 32'h11, KIND_DEBIT, 32'd0);
      wait_resp(got, st, k, b, n);
      tests++;
      if ({got, st, k, b} !== {1'b1, ST_OK, 32'h11, 32'd5}) begin
         fails++;
         $display("FAIL debit_zero got=%h exp=%h", {got, st, k, b},
                  {1'b1, ST_OK, 32'h11, 32'd5});
      end
   endtask

   task automatic test_drop();
      int cnt;
      logic [31:0] ks [3];
      logic [31:0] bs [3];
      tests++;
      if (drop_sticky !== 1'b0) begin
         fails++;
         $display("FAIL drop_before got=%b exp=0", drop_sticky);
      end
      send(SIG_QUERY, 32'h11, KIND_DEBIT, 32'd0);
      @(posedge tick_in);
      send(SIG_QUERY, 32'h12, KIND_DEBIT, 32'd0);
      send(SIG_QUERY, 32'h13, KIND_DEBIT, 32'd0);
      send(SIG_QUERY, 32'h10, KIND_DEBIT, 32'd0);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         ks[i] = '0;
         bs[i] = '0;
      end
      for (int i = 0; i < 60; i++) begin
         @(posedge tick_in);
         #1;
         if (resp_valid) begin
            if (cnt < 3) begin
               ks[cnt] = resp_key;
               bs[cnt] = resp_balance;
            end
            cnt++;
         end
      end
      tests++;
      if (drop_sticky !== 1'b1) begin
         fails++;
         $display("FAIL drop_sticky got=%b exp=1", drop_sticky);
      end
      tests++;
      if (cnt !== 3) begin
         fails++;
         $display("FAIL drop_count got=%0d exp=3", cnt);
      end
      tests++;
      if ({ks[0], ks[1], ks[2], bs[0], bs[1], bs[2]} !==
          {32'h11, 32'h12, 32'h13, 32'd5, 32'd1, 32'd2}) begin
         fails++;
         $display("FAIL drop_order got=%h %h %h / %h %h %h exp=11 12 13 / 5 1 2",
                  ks[0], ks[1], ks[2], bs[0], bs[1], bs[2]);
      end
   endtask

   task automatic test_reset_mid();
      logic got;
      logic [1:0] st;
      logic [31:0] k, b;
      int n;
      int cnt;
      logic [68:0] obs;
      send(SIG_TXN, 32'h55, KIND_CREDIT, 32'd9);
      repeat (3) @(posedge tick_in);
      #1;
      reset_in = 1'b1;
      #1;
      obs = {busy, resp_valid, resp_status, resp_key, resp_balance, drop_sticky};
      tests++;
      if (obs !== '0) begin
         fails++;
         $display("FAIL reset_mid_outputs got=%h exp=0", obs);
      end
      @(negedge tick_in);
      reset_in = 1'b0;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge tick_in);
         #1;
         if (resp_valid) cnt++;
      end
      tests++;
      if (cnt !== 0) begin
         fails++;
         $display("FAIL reset_mid_resp got=%0d exp=0", cnt);
      end
      send(SIG_QUERY, 32'h55, KIND_DEBIT, 32'd0);
      wait_resp(got, st, k, b, n);
      tests++;
      if ({got, st, k, b} !== {1'b1, ST_NOT_FOUND, 32'h55, 32'd0}) begin
         fails++;
         $display("FAIL reset_mid_query got=%h exp=%h", {got, st, k, b},
                  {1'b1, ST_NOT_FOUND, 32'h55, 32'd0});
      end
   endtask

   initial begin
      reset_in = 1'b1;
      repeat (3) @(posedge tick_in);
      #1;
      test_reset();
      @(negedge tick_in);
      reset_in = 1'b0;
      test_credit_new();
      test_debit_query();
      test_back_to_back();
      test_full_range();
      test_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
